// File: rtl/instr_loader.sv
// instr_loader: writer side of the decoder's instruction RAM.
// Accepts a host byte stream (valid/ready), assembles big-endian 16-bit words
// and writes them sequentially from address 0, holding the CPU while loading.
// Frame: LEN_HI, LEN_LO (N), then N x {WORD_HI, WORD_LO}, then an optional
// check byte. Optional feature macro: INSTR_LOADER_CHECKSUM_EN (adds the
// CHECK state and an 8-bit running sum; the frame must sum to 8'h00).
module instr_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [15:0]           ram_data,
    output logic                  ram_wren,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

`ifdef INSTR_LOADER_CHECKSUM_EN
    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, WORD_HI, WORD_LO, WRITE, CHECK, DONE, ERR
    } state_t;
    // After the last word (or an empty frame) the check byte is still due.
    localparam state_t FINISH = CHECK;
`else
    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, WORD_HI, WORD_LO, WRITE, DONE, ERR
    } state_t;
    localparam state_t FINISH = DONE;
`endif

    // Largest legal word count; one bit wider than the 16-bit length field.
    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            word_hi_q, word_hi_d;
    logic [15:0]           data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  rx_ready_q;
    logic                  wren_q;
    logic                  hold_q;
    logic                  done_q;
    logic                  error_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif

    logic                  fire;
    logic [16:0]           len_new;
    logic [16:0]           cnt_next;

    assign fire     = rx_valid && rx_ready_q;
    assign len_new  = {1'b0, len_q[15:8], rx_data};
    assign cnt_next = 17'(cnt_q) + 17'd1;

    // Next-state and datapath updates; a byte is consumed only when fire is high.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        word_hi_d = word_hi_q;
        data_d    = data_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN_HI;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            LEN_HI: begin
                if (fire) begin
                    len_d[15:8] = rx_data;
                    state_d     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (fire) begin
                    len_d[7:0] = rx_data;
                    if (len_new > CAPACITY) begin
                        state_d = ERR;
                    end else if (len_new == 17'd0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = WORD_HI;
                    end
                end
            end
            WORD_HI: begin
                if (fire) begin
                    word_hi_d = rx_data;
                    state_d   = WORD_LO;
                end
            end
            WORD_LO: begin
                if (fire) begin
                    data_d  = {word_hi_q, rx_data};
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // addr may roll over to 0 after a full-capacity load; never reused.
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_next == {1'b0, len_q}) begin
                    state_d = FINISH;
                end else begin
                    state_d = WORD_HI;
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            CHECK: begin
                if (fire) begin
                    state_d = (8'(sum_q + rx_data) == 8'h00) ? DONE : ERR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Running sum of every accepted byte, restarted when a new load begins.
    always_comb begin
        sum_d = sum_q;
        if ((state_q == IDLE || state_q == DONE || state_q == ERR) && start) begin
            sum_d = 8'h00;
        end else if (fire) begin
            sum_d = sum_q + rx_data;
        end
    end
`endif

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_hi_q  <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            rx_ready_q <= 1'b0;
            wren_q     <= 1'b0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_hi_q  <= word_hi_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rx_ready_q <= (state_d == LEN_HI) || (state_d == LEN_LO) ||
                          (state_d == WORD_HI) || (state_d == WORD_LO)
`ifdef INSTR_LOADER_CHECKSUM_EN
                          || (state_d == CHECK)
`endif
                          ;
            wren_q     <= (state_d == WRITE);
            // A failed load keeps the CPU held so it never runs a partial image.
            hold_q     <= (state_d != IDLE) && (state_d != DONE);
            done_q     <= (state_d == DONE);
            error_q    <= (state_d == ERR);
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign rx_ready     = rx_ready_q;
    assign ram_addr     = addr_q;
    assign ram_data     = data_q;
    assign ram_wren     = wren_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = cnt_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed frames plus randomized frames, checked
// against a frame-level reference (expected word list, writes, status flags).
module tb_instr_loader;
    localparam int AW = 8;
    localparam int CAP = 1 << AW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_data;
    logic          ram_wren;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    instr_loader #(.ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
        .cpu_hold(cpu_hold), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    int          vectors = 0;
    int          miscompares = 0;
    wr_t         wr_q[$];
    logic [7:0]  tx_q[$];
    logic [15:0] exp_words[$];

    // Record every RAM write as the instruction RAM would see it.
    always @(negedge clock) begin
        if (ram_wren) wr_q.push_back({ram_addr, ram_data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serialise a frame: 16-bit BE length, BE words, optional zero-sum check byte.
    task automatic make_bytes(input int len);
        logic [7:0] sum;
        tx_q.delete();
        tx_q.push_back(8'(len >> 8));
        tx_q.push_back(8'(len));
        foreach (exp_words[i]) begin
            tx_q.push_back(exp_words[i][15:8]);
            tx_q.push_back(exp_words[i][7:0]);
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        sum = 8'h00;
        foreach (tx_q[i]) sum = sum + tx_q[i];
        tx_q.push_back(8'h00 - sum);
`else
        sum = 8'h00;
`endif
    endtask

    task automatic random_words(input int n);
        exp_words.delete();
        for (int i = 0; i < n; i++) exp_words.push_back(16'($urandom));
    endtask

    task automatic do_start();
        @(negedge clock);
        start = 1'b1;
        wr_q.delete();
        @(negedge clock);
        start = 1'b0;
        check("start_hold", cpu_hold, 1);
        check("start_ready", rx_ready, 1);
        check("start_clr_done", {done, error}, 0);
        check("start_clr_words", words_loaded, 0);
    endtask

    // mode 0: always valid, 1: valid every other cycle, 2: random valid.
    task automatic send_bytes(input int mode, input bit pulse_start);
        int idx = 0;
        int cyc = 0;
        bit fire;
        while (idx < tx_q.size() && cyc < 4000) begin
            @(negedge clock);
            cyc++;
            case (mode)
                0: rx_valid = 1'b1;
                1: rx_valid = cyc[0];
                default: rx_valid = 1'($urandom_range(0, 1));
            endcase
            rx_data = rx_valid ? tx_q[idx] : 8'($urandom);
            start = pulse_start ? ($urandom_range(0, 3) == 0) : 1'b0;
            fire = rx_valid && rx_ready;
            @(posedge clock);
            if (fire) idx++;
        end
        @(negedge clock);
        rx_valid = 1'b0;
        start = 1'b0;
        check("bytes_accepted", idx, tx_q.size());
    endtask

    task automatic wait_end();
        int k = 0;
        while (!(done || error) && k < 50) begin
            @(negedge clock);
            k++;
        end
        check("finish_in_time", 32'(k < 50), 1);
    endtask

    task automatic verify(input string tag, input bit ok);
        check({tag, "_done"}, done, 32'(ok));
        check({tag, "_error"}, error, 32'(!ok));
        check({tag, "_hold"}, cpu_hold, 32'(!ok));
        check({tag, "_ready"}, rx_ready, 0);
        check({tag, "_words"}, words_loaded, exp_words.size());
        check({tag, "_nwrites"}, wr_q.size(), exp_words.size());
        foreach (exp_words[i]) begin
            if (i < wr_q.size()) begin
                check({tag, "_addr"}, wr_q[i].a, i % CAP);
                check({tag, "_data"}, wr_q[i].d, exp_words[i]);
            end
        end
    endtask

    initial begin
        // Reset held with a byte offered: nothing consumed, all outputs low.
        reset_n = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'h5A;
        repeat (2) @(negedge clock);
        check("rst_ready", rx_ready, 0);
        check("rst_wren", ram_wren, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_flags", {done, error}, 0);
        check("rst_words", words_loaded, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_data", ram_data, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_ready", rx_ready, 0);
        check("idle_hold", cpu_hold, 0);
        rx_valid = 1'b0;

        // Two-word load with fixed bytes 00 02 12 34 AB CD.
        exp_words = '{16'h1234, 16'hABCD};
        make_bytes(2);
        do_start();
        send_bytes(0, 1'b0);
        wait_end();
        verify("two_words", 1'b1);

`ifdef INSTR_LOADER_CHECKSUM_EN
        // Good check byte, then a corrupted one.
        exp_words = '{16'h1234};
        make_bytes(1);
        check("cksum_byte", tx_q[4], 8'hB9);
        do_start();
        send_bytes(0, 1'b0);
        wait_end();
        verify("cksum_ok", 1'b1);
        tx_q[4] = 8'h00;
        do_start();
        send_bytes(2, 1'b0);
        wait_end();
        verify("cksum_bad", 1'b0);
`endif

        // Oversized length aborts right after LEN_LO with no writes.
        exp_words.delete();
        tx_q = '{8'h01, 8'h01};
        do_start();
        send_bytes(0, 1'b0);
        wait_end();
        verify("too_long", 1'b0);

        // Empty frame completes immediately.
        exp_words.delete();
        make_bytes(0);
        do_start();
        send_bytes(0, 1'b0);
        wait_end();
        verify("empty", 1'b1);

        // Full-capacity load, last write at all-ones address.
        random_words(CAP);
        make_bytes(CAP);
        do_start();
        send_bytes(2, 1'b0);
        wait_end();
        verify("full", 1'b1);

        // Gapped valid with stray start pulses mid-load.
        random_words(3);
        make_bytes(3);
        do_start();
        send_bytes(1, 1'b1);
        wait_end();
        verify("gapped", 1'b1);

        // Reset after the first word is written, then reload one word.
        random_words(3);
        make_bytes(3);
        do_start();
        tx_q = tx_q[0:3];
        send_bytes(0, 1'b0);
        @(negedge clock);
        check("part_writes", wr_q.size(), 1);
        reset_n = 1'b0;
        @(negedge clock);
        check("midrst_hold", cpu_hold, 0);
        check("midrst_ready", rx_ready, 0);
        check("midrst_flags", {done, error}, 0);
        check("midrst_words", words_loaded, 0);
        reset_n = 1'b1;
        random_words(1);
        make_bytes(1);
        do_start();
        send_bytes(0, 1'b0);
        wait_end();
        verify("reload", 1'b1);

        // Randomized frames.
        for (int r = 0; r < 10; r++) begin
            random_words($urandom_range(1, 10));
            make_bytes(exp_words.size());
            do_start();
            send_bytes($urandom_range(0, 2), 1'($urandom_range(0, 1)));
            wait_end();
            verify("rand", 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
